write_back: RTL and testbench
=============================

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter HART_ID, default 0, value returned by CSR mhartid (0xF14).
REQ-002 Parameter MTVEC_RESET, default 32'h0, reset value of mtvec.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 stop  in  1  pipeline stall; 1 = suppress all architectural updates.
REQ-006 in_valid  in  1  instruction present in this stage.
REQ-007 in_wb_reg  in  1  write in_wb_data to GPR in_reg_d.
REQ-008 in_reg_d  in  5  destination GPR index.
REQ-009 in_wb_data  in  32  GPR write data.
REQ-010 in_wb_csr  in  1  write in_csr_data to CSR in_csr_addr.
REQ-011 in_csr_addr  in  12  CSR write address.
REQ-012 in_csr_data  in  32  CSR write data.
REQ-013 trap_req  in  1  trap taken this cycle.
REQ-014 trap_pc  in  32  PC saved to mepc on trap.
REQ-015 trap_cause  in  32  value saved to mcause on trap.
REQ-016 rs1_addr, rs2_addr  in  5 each  GPR read indices.
REQ-017 rs1_data, rs2_data  out  32 each  GPR read data, combinational.
REQ-018 csr_addr  in  12  CSR read index.
REQ-019 csr_data  out  32  CSR read data, combinational.
REQ-020 csr_trap_vec_data  out  32  current mtvec.
REQ-021 csr_exception_pc_data  out  32  current mepc.

Function
REQ-022 GPR file SHALL be 32 x 32 bit; x0 SHALL read 0 and ignore writes.
REQ-023 GPR write SHALL occur at posedge when in_valid & in_wb_reg & !stop & in_reg_d != 0.
REQ-024 Read ports SHALL bypass: if a qualifying write targets rsN_addr in the same cycle, rsN_data SHALL equal in_wb_data.
REQ-025 Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, mhartid 0xF14.
REQ-026 Unimplemented CSR reads SHALL return 0; writes to them and to mhartid SHALL be ignored.
REQ-027 CSR write SHALL occur at posedge when in_valid & in_wb_csr & !stop; visible on csr_data next cycle (no CSR bypass).
REQ-028 mstatus: only MIE (bit 3) and MPIE (bit 7) writable; other bits read 0.
REQ-029 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on write.
REQ-030 mcycle SHALL be a 64-bit counter incrementing every cycle, including during stop; wraps 2^64-1 -> 0.
REQ-031 minstret SHALL be 64-bit, increment when in_valid & !stop & !trap_req; wraps.
REQ-032 CSR write to a counter half SHALL override that cycle's increment for that half; other half keeps its pre-increment value (no carry that cycle).
REQ-033 Trap (trap_req & !stop): mepc <= trap_pc, mcause <= trap_cause, MPIE <= MIE, MIE <= 0; GPR and CSR writes of this instruction suppressed.
REQ-034 Trap and CSR write to mepc/mcause/mstatus in same cycle: trap SHALL win.
REQ-035 trap_req while stop = 1 SHALL be ignored (upstream re-presents it).
REQ-036 csr_trap_vec_data and csr_exception_pc_data SHALL reflect registered values, updated one cycle after write.

Reset
REQ-037 On reset = 0 at posedge: all GPRs, mstatus, mscratch, mepc, mcause, mcycle, minstret <= 0; mtvec <= MTVEC_RESET.
REQ-038 Reset SHALL override stop, trap_req and all writes in the same cycle; mid-operation writes are lost.
REQ-039 Counters SHALL resume counting on first cycle with reset = 1 (mcycle = 1 one cycle later).

Verification
REQ-040 Write x5 = 32'hDEADBEEF, rs1_addr = 5 same cycle -> rs1_data = DEADBEEF immediately and after posedge.
REQ-041 Write x0 = 32'h1234 -> rs2_addr = 0 reads 0 always.
REQ-042 stop = 1 with GPR write x7 = 1 and CSR write mscratch = 5 -> both unchanged; mcycle still +1, minstret unchanged.
REQ-043 mstatus = 32'h8 then trap_req, trap_pc = 32'h100, cause = 32'hB, simultaneous CSR write mepc = 32'h200 -> mepc = 100, mcause = B, mstatus = 32'h80.
REQ-044 CSR write mcycle = 32'hFFFFFFFF, then 1 cycle -> mcycle = 0, mcycleh +1.
REQ-045 Write mtvec = 32'h8003 -> csr_trap_vec_data = 32'h8000 next cycle; reset = 0 -> MTVEC_RESET.

Source files
------------

// File: rtl/write_back_if.sv
// Write-back stage bundle: retiring instruction, trap request, GPR and CSR read ports.
interface write_back_if;
  logic        stop;
  logic        in_valid;
  logic        in_wb_reg;
  logic [4:0]  in_reg_d;
  logic [31:0] in_wb_data;
  logic        in_wb_csr;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_data;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [11:0] csr_addr;
  logic [31:0] csr_data;
  logic [31:0] csr_trap_vec_data;
  logic [31:0] csr_exception_pc_data;

  // Pipeline side: drives the retiring instruction and read indices.
  modport master (
    output stop, in_valid, in_wb_reg, in_reg_d, in_wb_data,
    output in_wb_csr, in_csr_addr, in_csr_data,
    output trap_req, trap_pc, trap_cause,
    output rs1_addr, rs2_addr, csr_addr,
    input  rs1_data, rs2_data, csr_data, csr_trap_vec_data, csr_exception_pc_data
  );

  // Register-file side.
  modport slave (
    input  stop, in_valid, in_wb_reg, in_reg_d, in_wb_data,
    input  in_wb_csr, in_csr_addr, in_csr_data,
    input  trap_req, trap_pc, trap_cause,
    input  rs1_addr, rs2_addr, csr_addr,
    output rs1_data, rs2_data, csr_data, csr_trap_vec_data, csr_exception_pc_data
  );
endinterface

// File: rtl/write_back.sv
// Write-back stage: 32x32 GPR file with write bypass, machine-mode CSRs, 64-bit counters
// and trap entry bookkeeping.
module write_back #(
  parameter int unsigned HART_ID     = 0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input logic         clk,
  input logic         reset,
  write_back_if.slave bus
);

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  logic        trap_take;
  logic        gpr_we;
  logic        csr_we;
  logic        instret_inc;

  logic [31:0] gpr_q [32];

  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // A trap presented under stall is dropped; the upstream stage re-presents it.
  assign trap_take   = bus.trap_req & ~bus.stop;
  // A taking trap squashes the instruction's own GPR/CSR writes.
  assign gpr_we      = bus.in_valid & bus.in_wb_reg & ~bus.stop & ~trap_take &
                       (bus.in_reg_d != 5'd0);
  assign csr_we      = bus.in_valid & bus.in_wb_csr & ~bus.stop & ~trap_take;
  assign instret_inc = bus.in_valid & ~bus.stop & ~bus.trap_req;

  // GPR file update; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr_q[bus.in_reg_d] <= bus.in_wb_data;
    end
  end

  // GPR read ports with same-cycle bypass of the pending write.
  always_comb begin
    bus.rs1_data = gpr_q[bus.rs1_addr];
    bus.rs2_data = gpr_q[bus.rs2_addr];
    if (gpr_we && (bus.in_reg_d == bus.rs1_addr)) bus.rs1_data = bus.in_wb_data;
    if (gpr_we && (bus.in_reg_d == bus.rs2_addr)) bus.rs2_data = bus.in_wb_data;
    if (bus.rs1_addr == 5'd0) bus.rs1_data = '0;
    if (bus.rs2_addr == 5'd0) bus.rs2_data = '0;
  end

  // Counter next state: a write to one half replaces the increment for the whole counter
  // that cycle, so the untouched half holds its old value and no carry propagates.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (csr_we && (bus.in_csr_addr == CsrMcycle)) begin
      mcycle_d = {mcycle_q[63:32], bus.in_csr_data};
    end else if (csr_we && (bus.in_csr_addr == CsrMcycleh)) begin
      mcycle_d = {bus.in_csr_data, mcycle_q[31:0]};
    end

    minstret_d = instret_inc ? (minstret_q + 64'd1) : minstret_q;
    if (csr_we && (bus.in_csr_addr == CsrMinstret)) begin
      minstret_d = {minstret_q[63:32], bus.in_csr_data};
    end else if (csr_we && (bus.in_csr_addr == CsrMinstreth)) begin
      minstret_d = {bus.in_csr_data, minstret_q[31:0]};
    end
  end

  // CSR state: reset first, then trap entry, then software CSR writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (trap_take) begin
        mepc_q   <= bus.trap_pc;
        mcause_q <= bus.trap_cause;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (csr_we) begin
        case (bus.in_csr_addr)
          CsrMstatus: begin
            mie_q  <= bus.in_csr_data[3];
            mpie_q <= bus.in_csr_data[7];
          end
          CsrMtvec:    mtvec_q    <= {bus.in_csr_data[31:2], 2'b00};
          CsrMscratch: mscratch_q <= bus.in_csr_data;
          CsrMepc:     mepc_q     <= {bus.in_csr_data[31:2], 2'b00};
          CsrMcause:   mcause_q   <= bus.in_csr_data;
          default: ;
        endcase
      end
    end
  end

  // CSR read mux; unimplemented addresses read zero.
  always_comb begin
    bus.csr_data = '0;
    case (bus.csr_addr)
      CsrMstatus:   bus.csr_data = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CsrMtvec:     bus.csr_data = mtvec_q;
      CsrMscratch:  bus.csr_data = mscratch_q;
      CsrMepc:      bus.csr_data = mepc_q;
      CsrMcause:    bus.csr_data = mcause_q;
      CsrMcycle:    bus.csr_data = mcycle_q[31:0];
      CsrMcycleh:   bus.csr_data = mcycle_q[63:32];
      CsrMinstret:  bus.csr_data = minstret_q[31:0];
      CsrMinstreth: bus.csr_data = minstret_q[63:32];
      CsrMhartid:   bus.csr_data = HART_ID;
      default:      bus.csr_data = '0;
    endcase
  end

  assign bus.csr_trap_vec_data     = mtvec_q;
  assign bus.csr_exception_pc_data = mepc_q;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: expectations are queued as stimulus is applied and
// popped when the corresponding DUT output is sampled.
module tb_write_back;

  localparam int unsigned HartId     = 3;
  localparam logic [31:0] MtvecReset = 32'h0000_1000;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;

  write_back_if bus ();

  write_back #(
    .HART_ID     (HartId),
    .MTVEC_RESET (MtvecReset)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.stop        = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_wb_reg   = 1'b0;
    bus.in_reg_d    = 5'd0;
    bus.in_wb_data  = 32'd0;
    bus.in_wb_csr   = 1'b0;
    bus.in_csr_addr = 12'd0;
    bus.in_csr_data = 32'd0;
    bus.trap_req    = 1'b0;
    bus.trap_pc     = 32'd0;
    bus.trap_cause  = 32'd0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %h with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd_csr(input string tag, input logic [11:0] a, input logic [31:0] v);
    push(tag, v);
    bus.csr_addr = a;
    #1;
    compare(bus.csr_data);
  endtask

  task automatic rd_rs1(input string tag, input logic [4:0] a, input logic [31:0] v);
    push(tag, v);
    bus.rs1_addr = a;
    #1;
    compare(bus.rs1_data);
  endtask

  task automatic rd_rs2(input string tag, input logic [4:0] a, input logic [31:0] v);
    push(tag, v);
    bus.rs2_addr = a;
    #1;
    compare(bus.rs2_data);
  endtask

  task automatic gpr_wr(input logic [4:0] rd, input logic [31:0] d);
    bus.in_valid   = 1'b1;
    bus.in_wb_reg  = 1'b1;
    bus.in_reg_d   = rd;
    bus.in_wb_data = d;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.in_valid    = 1'b1;
    bus.in_wb_csr   = 1'b1;
    bus.in_csr_addr = a;
    bus.in_csr_data = d;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    idle();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    bus.csr_addr = 12'd0;

    // Reset, then release; counters count from the first cycle out of reset.
    reset = 1'b0;
    tick();
    tick();
    push("rst_mtvec_out", MtvecReset);
    compare(bus.csr_trap_vec_data);
    push("rst_mepc_out", 32'd0);
    compare(bus.csr_exception_pc_data);
    rd_csr("rst_mcycle", 12'hB00, 32'd0);
    cyc   = 0;
    reset = 1'b1;
    tick();
    rd_csr("mcycle_first", 12'hB00, cyc);
    rd_csr("minstret_rst", 12'hB02, 32'd0);
    rd_csr("mhartid", 12'hF14, HartId);
    rd_csr("mtvec_rst", 12'h305, MtvecReset);
    rd_csr("unimpl_rd", 12'h123, 32'd0);

    // x5 write with same-cycle bypass, then registered value.
    gpr_wr(5'd5, 32'hDEADBEEF);
    rd_rs1("bypass_x5", 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rd_rs1("reg_x5", 5'd5, 32'hDEADBEEF);

    // x0 is hardwired to zero.
    gpr_wr(5'd0, 32'h1234);
    rd_rs2("x0_same", 5'd0, 32'd0);
    tick();
    idle();
    rd_rs2("x0_after", 5'd0, 32'd0);

    // mscratch baseline, then a stalled instruction must change nothing but mcycle.
    csr_wr(12'h340, 32'd9);
    tick();
    idle();
    bus.stop = 1'b1;
    gpr_wr(5'd7, 32'd1);
    csr_wr(12'h340, 32'd5);
    rd_rs1("stop_no_bypass", 5'd7, 32'd0);
    tick();
    idle();
    rd_rs1("stop_x7", 5'd7, 32'd0);
    rd_csr("stop_mscratch", 12'h340, 32'd9);
    rd_csr("stop_mcycle", 12'hB00, cyc);
    rd_csr("stop_minstret", 12'hB02, 32'd3);

    // Trap beats a simultaneous mepc write and squashes the GPR write.
    csr_wr(12'h300, 32'h8);
    tick();
    idle();
    rd_csr("mstatus_mie", 12'h300, 32'h8);
    bus.trap_req   = 1'b1;
    bus.trap_pc    = 32'h100;
    bus.trap_cause = 32'hB;
    csr_wr(12'h341, 32'h200);
    gpr_wr(5'd9, 32'h55);
    tick();
    idle();
    rd_csr("trap_mepc", 12'h341, 32'h100);
    push("trap_mepc_out", 32'h100);
    compare(bus.csr_exception_pc_data);
    rd_csr("trap_mcause", 12'h342, 32'hB);
    rd_csr("trap_mstatus", 12'h300, 32'h80);
    rd_rs1("trap_x9", 5'd9, 32'd0);
    rd_csr("trap_minstret", 12'hB02, 32'd4);

    // mcycle low-half write, then carry into mcycleh.
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    idle();
    rd_csr("mcycle_wr_lo", 12'hB00, 32'hFFFF_FFFF);
    rd_csr("mcycle_wr_hi", 12'hB80, 32'd0);
    tick();
    rd_csr("mcycle_wrap_lo", 12'hB00, 32'd0);
    rd_csr("mcycle_wrap_hi", 12'hB80, 32'd1);

    // minstreth write suppresses that cycle's increment of the low half.
    csr_wr(12'hB82, 32'd7);
    tick();
    idle();
    rd_csr("minstret_lo_hold", 12'hB02, 32'd5);
    rd_csr("minstreth_wr", 12'hB82, 32'd7);

    // Writes to mhartid and to an unimplemented CSR are ignored.
    csr_wr(12'hF14, 32'h55);
    tick();
    csr_wr(12'h7C0, 32'h1);
    tick();
    idle();
    rd_csr("mhartid_ro", 12'hF14, HartId);
    rd_csr("unimpl_wr", 12'h7C0, 32'd0);
    rd_csr("minstret_cnt", 12'hB02, 32'd7);

    // mtvec/mepc low bits cleared; no CSR read bypass during the write cycle.
    csr_wr(12'h305, 32'h8003);
    rd_csr("mtvec_no_bypass", 12'h305, MtvecReset);
    tick();
    csr_wr(12'h341, 32'h203);
    push("mtvec_out", 32'h8000);
    compare(bus.csr_trap_vec_data);
    rd_csr("mtvec_rd", 12'h305, 32'h8000);
    tick();
    idle();
    rd_csr("mepc_align", 12'h341, 32'h200);

    // Reset overrides simultaneous writes.
    reset = 1'b0;
    gpr_wr(5'd5, 32'h77);
    csr_wr(12'h340, 32'hAA);
    tick();
    reset = 1'b1;
    idle();
    push("rst2_mtvec_out", MtvecReset);
    compare(bus.csr_trap_vec_data);
    rd_rs1("rst2_x5", 5'd5, 32'd0);
    rd_csr("rst2_mscratch", 12'h340, 32'd0);
    rd_csr("rst2_mstatus", 12'h300, 32'd0);
    rd_csr("rst2_mcycle", 12'hB00, 32'd0);
    tick();
    rd_csr("rst2_mcycle_run", 12'hB00, 32'd1);
    rd_csr("rst2_minstret", 12'hB02, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
